axi4lite_regfile: RTL

Parametrised AXI4-Lite slave register file, the next-generation replacement for the single-register slave used in the pin-driven AXI4-Lite top. It supports a configurable number of registers and data width, and accepts AW and W independently and in either order. Out-of-range accesses get SLVERR. Every register is exposed on a flat output bus for downstream logic, with a per-register write-strobe pulse.

---
 rtl/axi4lite_regfile.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_regfile.sv
// axi4lite_regfile
//   AXI4-Lite slave exposing NUM_REGS registers of C_S_AXI_DATA_WIDTH bits.
//   AW and W are accepted independently, in either order, and held until both
//   are present; the write then commits on the next edge. Accesses whose index
//   is not below NUM_REGS complete with SLVERR and touch nothing.
//
//   Build option: define AXI4LITE_REGFILE_WSTRB_EN to honour s_axi_wstrb
//   byte lanes on commit. Left undefined, every in-range commit writes the
//   full word. Response and timing behaviour are the same either way.
//
// Ports
//   s_axi_aclk, s_axi_aresetn   clock, async active-low reset
//   s_axi_aw* / s_axi_w*        write address / write data channels
//   s_axi_b*                    write response channel
//   s_axi_ar* / s_axi_r*        read address / read data channels
//   reg_out                     all registers, register i at [i*DW +: DW]
//   reg_wr                      one-cycle pulse per register after its commit
module axi4lite_regfile #(
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS           = 4
) (
   input  logic                                     s_axi_aclk,
   input  logic                                     s_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
   input  logic                                     s_axi_awvalid,
   output logic                                     s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
   input  logic                                     s_axi_wvalid,
   output logic                                     s_axi_wready,
   output logic [1:0]                               s_axi_bresp,
   output logic                                     s_axi_bvalid,
   input  logic                                     s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
   input  logic                                     s_axi_arvalid,
   output logic                                     s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
   output logic [1:0]                               s_axi_rresp,
   output logic                                     s_axi_rvalid,
   input  logic                                     s_axi_rready,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
   output logic [NUM_REGS-1:0]                      reg_wr
);

   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int STRB_W   = DW / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                           aw_full_q, aw_full_d;
   logic [IDX_W-1:0]               aw_idx_q, aw_idx_d;
   logic                           w_full_q, w_full_d;
   logic [DW-1:0]                  wdata_q, wdata_d;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
   logic [STRB_W-1:0]              wstrb_q, wstrb_d;
`endif
   logic                           bvalid_q, bvalid_d;
   logic [1:0]                     bresp_q, bresp_d;
   logic                           rvalid_q, rvalid_d;
   logic [DW-1:0]                  rdata_q, rdata_d;
   logic [1:0]                     rresp_q, rresp_d;
   logic [NUM_REGS-1:0][DW-1:0]    regs_q, regs_d;
   logic [NUM_REGS-1:0]            reg_wr_q, reg_wr_d;

   logic                           commit;
   logic [31:0]                    w_idx, r_idx;
   logic                           unused_inputs;

   assign s_axi_awready = !aw_full_q && !bvalid_q;
   assign s_axi_wready  = !w_full_q && !bvalid_q;
   assign s_axi_arready = !rvalid_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign reg_out       = regs_q;
   assign reg_wr        = reg_wr_q;

   // Only the word index of each address is decoded; sub-word address bits
   // (and wstrb when lane masking is compiled out) are intentionally ignored.
   assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

   // Indices widened to 32 bits so NUM_REGS == 2^IDX_W compares correctly.
   assign w_idx  = 32'(aw_idx_q);
   assign r_idx  = 32'(s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);
   assign commit = aw_full_q && w_full_q && !bvalid_q;

   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
      wstrb_d   = wstrb_q;
`endif
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      regs_d    = regs_q;
      reg_wr_d  = '0;

      // Commit and new AW/W handshakes are mutually exclusive: commit needs
      // both flags set, which already holds both readies low.
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (w_idx < NUM_REGS) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (w_idx == i) begin
                  reg_wr_d[i] = 1'b1;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
                  for (int k = 0; k < STRB_W; k++) begin
                     if (wstrb_q[k]) regs_d[i][k*8 +: 8] = wdata_q[k*8 +: 8];
                  end
`else
                  regs_d[i] = wdata_q;
`endif
               end
            end
         end else begin
            bresp_d = RESP_SLVERR;
         end
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end

      if (s_axi_awvalid && s_axi_awready) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (s_axi_wvalid && s_axi_wready) begin
         w_full_d = 1'b1;
         wdata_d  = s_axi_wdata;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
         wstrb_d  = s_axi_wstrb;
`endif
      end

      // Reads sample regs_q, so a read on a commit edge sees the old value.
      if (s_axi_arvalid && s_axi_arready) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         if (r_idx < NUM_REGS) begin
            rresp_d = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (r_idx == i) rdata_d = regs_q[i];
            end
         end
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         wdata_q   <= '0;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
         wstrb_q   <= '0;
`endif
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         regs_q    <= '0;
         reg_wr_q  <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         wdata_q   <= wdata_d;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
         wstrb_q   <= wstrb_d;
`endif
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
         reg_wr_q  <= reg_wr_d;
      end
   end

endmodule
